// File: rtl/qk_key_arbiter_if.sv
// Handshake bundle between the key-generation channels, the arbiter and the display consumer.
// slave = arbiter view, master = channel/consumer (testbench) view.
interface qk_key_arbiter_if #(
  parameter int N_CH  = 3,
  parameter int KEY_W = 32,
  parameter int ERR_W = 8
);
  logic [N_CH-1:0]       ch_valid;
  logic [N_CH-1:0]       ch_ready;
  logic [N_CH*ERR_W-1:0] ch_error;
  logic [N_CH*KEY_W-1:0] ch_akey;
  logic [N_CH*KEY_W-1:0] ch_bkey;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_ch;
  logic [ERR_W-1:0]      out_error;
  logic [KEY_W-1:0]      out_akey;
  logic [KEY_W-1:0]      out_bkey;

  modport slave (
    input  ch_valid, ch_error, ch_akey, ch_bkey, out_ready,
    output ch_ready, out_valid, out_ch, out_error, out_akey, out_bkey
  );

  modport master (
    output ch_valid, ch_error, ch_akey, ch_bkey, out_ready,
    input  ch_ready, out_valid, out_ch, out_error, out_akey, out_bkey
  );
endinterface

// File: rtl/qk_key_arbiter.sv
// Round-robin collector for N_CH key-generation channels; screens error/mismatch, forwards one result at a time.
// Optional macro QK_MISMATCH_FORWARD_EN: forward A/B mismatches with an XOR syndrome in out_bkey (counted as discards).
module qk_key_arbiter #(
  parameter int               N_CH       = 3,
  parameter int               KEY_W      = 32,
  parameter int               ERR_W      = 8,
  parameter logic [ERR_W-1:0] ERR_THRESH = ERR_W'(10)
) (
  input  logic                   clk,
  input  logic                   rst,
  qk_key_arbiter_if.slave        bus,
  output logic [15:0]            acc_cnt,
  output logic [15:0]            dis_cnt
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, grant;
  logic             gnt_vld;
  logic [N_CH-1:0]  ready;
  logic             out_valid_q;
  logic [2:0]       out_ch_q;
  logic [ERR_W-1:0] out_error_q;
  logic [KEY_W-1:0] out_akey_q, out_bkey_q;
  logic [15:0]      acc_q, dis_q;
  logic             err_bad, mism;
`ifdef QK_MISMATCH_FORWARD_EN
  logic             mm_q;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scan from the far end back toward rr_ptr so the closest requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_CH;
      if (bus.ch_valid[idx]) begin
        grant   = PTR_W'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == IDLE && gnt_vld) ready[grant] = 1'b1;
  end

  assign rr_ptr_d = (grant == PTR_W'(N_CH - 1)) ? '0 : grant + PTR_W'(1);
  assign err_bad  = out_error_q > ERR_THRESH;
  assign mism     = out_akey_q != out_bkey_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_error_q <= '0;
      out_akey_q  <= '0;
      out_bkey_q  <= '0;
      acc_q       <= '0;
      dis_q       <= '0;
`ifdef QK_MISMATCH_FORWARD_EN
      mm_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          out_ch_q    <= 3'(grant);
          out_error_q <= bus.ch_error[grant*ERR_W +: ERR_W];
          out_akey_q  <= bus.ch_akey[grant*KEY_W +: KEY_W];
          out_bkey_q  <= bus.ch_bkey[grant*KEY_W +: KEY_W];
          rr_ptr_q    <= rr_ptr_d;
          state_q     <= CHECK;
        end
        CHECK: begin
`ifdef QK_MISMATCH_FORWARD_EN
          if (err_bad) begin
            dis_q   <= sat_inc(dis_q);
            state_q <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
            mm_q        <= mism;
            if (mism) out_bkey_q <= out_akey_q ^ out_bkey_q;
            state_q     <= OUT;
          end
`else
          if (err_bad || mism) begin
            dis_q   <= sat_inc(dis_q);
            state_q <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
`endif
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
`ifdef QK_MISMATCH_FORWARD_EN
          if (mm_q) dis_q <= sat_inc(dis_q);
          else      acc_q <= sat_inc(acc_q);
`else
          acc_q <= sat_inc(acc_q);
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ch_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_error = out_error_q;
  assign bus.out_akey  = out_akey_q;
  assign bus.out_bkey  = out_bkey_q;
  assign acc_cnt       = acc_q;
  assign dis_cnt       = dis_q;
endmodule

// File: tb/tb_qk_key_arbiter.sv
// Scoreboard bench for qk_key_arbiter: a cycle model predicts grants, screening and counters.
module tb_qk_key_arbiter;
  localparam int N = 3;
`ifdef QK_MISMATCH_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qk_key_arbiter_if #(.N_CH(N), .KEY_W(32), .ERR_W(8)) bus();
  logic [15:0] acc_cnt, dis_cnt;

  qk_key_arbiter #(.N_CH(N), .KEY_W(32), .ERR_W(8), .ERR_THRESH(8'd10)) dut (
    .clk(clk), .rst(rst), .bus(bus), .acc_cnt(acc_cnt), .dis_cnt(dis_cnt)
  );

  logic [7:0]  err [N];
  logic [31:0] ak  [N];
  logic [31:0] bk  [N];

  always_comb begin
    bus.ch_error = '0;
    bus.ch_akey  = '0;
    bus.ch_bkey  = '0;
    for (int i = 0; i < N; i++) begin
      bus.ch_error[i*8 +: 8]   = err[i];
      bus.ch_akey[i*32 +: 32]  = ak[i];
      bus.ch_bkey[i*32 +: 32]  = bk[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [7:0]  err;
    logic [31:0] ak;
    logic [31:0] bk;
    logic        mm;
  } exp_t;

  exp_t        sb_q[$];
  int          order_q[$];
  int          m_st, m_ptr;
  logic [15:0] m_acc, m_dis;
  exp_t        m_cap;

  // Model: 0=IDLE 1=CHECK 2=OUT; updated each negedge for the following posedge.
  always @(negedge clk) begin
    int       g;
    logic [N-1:0] er;
    exp_t     top;
    if (!rst) begin
      m_st = 0; m_ptr = 0; m_acc = 0; m_dis = 0;
      sb_q.delete();
    end else begin
      chk("acc_cnt", acc_cnt, m_acc);
      chk("dis_cnt", dis_cnt, m_dis);
      case (m_st)
        0: begin
          g = -1;
          for (int k = N - 1; k >= 0; k--)
            if (bus.ch_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          er = '0;
          if (g >= 0) er[g] = 1'b1;
          chk("ch_ready_idle", bus.ch_ready, er);
          chk("out_valid_idle", bus.out_valid, 0);
          if (g >= 0) begin
            m_cap.ch = 3'(g); m_cap.err = err[g];
            m_cap.ak = ak[g]; m_cap.bk = bk[g]; m_cap.mm = 1'b0;
            m_ptr = (g + 1) % N;
            m_st  = 1;
          end
        end
        1: begin
          chk("ch_ready_check", bus.ch_ready, 0);
          chk("out_valid_check", bus.out_valid, 0);
          if (m_cap.err > 8'd10 || (!FWD && m_cap.ak != m_cap.bk)) begin
            m_dis = m_dis + 1;
            m_st  = 0;
          end else begin
            if (m_cap.ak != m_cap.bk) begin
              m_cap.bk = m_cap.ak ^ m_cap.bk;
              m_cap.mm = 1'b1;
            end
            sb_q.push_back(m_cap);
            m_st = 2;
          end
        end
        default: begin
          chk("ch_ready_out", bus.ch_ready, 0);
          chk("out_valid_out", bus.out_valid, 1);
          if (sb_q.size() == 0) chk("sb_empty", 1, 0);
          else begin
            top = sb_q[0];
            chk("out_ch", bus.out_ch, top.ch);
            chk("out_error", bus.out_error, top.err);
            chk("out_akey", bus.out_akey, top.ak);
            chk("out_bkey", bus.out_bkey, top.bk);
            if (bus.out_ready) begin
              order_q.push_back(int'(bus.out_ch));
              if (top.mm) m_dis = m_dis + 1;
              else        m_acc = m_acc + 1;
              top  = sb_q.pop_front();
              m_st = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic set_ch(input int c, input logic [7:0] e, input logic [31:0] a, input logic [31:0] b);
    err[c] = e; ak[c] = a; bk[c] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk); #1; t++;
    end while (bus.ch_ready == '0 && t < 50);
    if (bus.ch_ready == '0) chk(tag, 0, 1);
  endtask

  task automatic send(input logic [N-1:0] m);
    bus.ch_valid = m;
    wait_grant("grant_timeout");
    @(posedge clk); #1;
    bus.ch_valid = '0;
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (order_q.size() < n && t < 300) begin
      @(negedge clk); #1; t++;
    end
    if (order_q.size() < n) chk("result_timeout", order_q.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    int t;
    bus.ch_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_ch(i, 8'd0, 32'd0, 32'd0);
    idle(2);
    chk("rst_ch_ready", bus.ch_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_out_error", bus.out_error, 0);
    chk("rst_out_akey", bus.out_akey, 0);
    chk("rst_out_bkey", bus.out_bkey, 0);
    chk("rst_acc", acc_cnt, 0);
    chk("rst_dis", dis_cnt, 0);
    rst = 1'b1;
    idle(1);

    // single result on channel 1
    bus.out_ready = 1'b1;
    set_ch(1, 8'd4, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    send(3'b010);
    idle(6);
    chk("single_acc", acc_cnt, 1);
    chk("single_ch", order_q.size() > 0 ? order_q[order_q.size()-1] : -1, 1);

    // threshold edge: 10 passes, 11 is dropped
    set_ch(0, 8'd10, 32'h1234_5678, 32'h1234_5678);
    send(3'b001);
    idle(6);
    chk("thresh10_acc", acc_cnt, 2);
    set_ch(2, 8'd11, 32'h1234_5678, 32'h1234_5678);
    send(3'b100);
    idle(6);
    chk("thresh11_acc", acc_cnt, 2);
    chk("thresh11_dis", dis_cnt, 1);

    // A/B mismatch
    set_ch(0, 8'd0, 32'h1, 32'h3);
    send(3'b001);
    idle(6);
    chk("mism_acc", acc_cnt, 2);
    chk("mism_dis", dis_cnt, 2);
`ifdef QK_MISMATCH_FORWARD_EN
    chk("mism_fwd_cnt", order_q.size(), 3);
`else
    chk("mism_fwd_cnt", order_q.size(), 2);
`endif

    // fairness: strict rotation from a fresh pointer
    do_reset();
    order_q.delete();
    for (int i = 0; i < N; i++) set_ch(i, 8'd0, 32'h100 + i, 32'h100 + i);
    bus.ch_valid = '1;
    wait_results(9);
    @(posedge clk); #1;
    bus.ch_valid = '0;
    idle(4);
    chk("fair_acc", acc_cnt, 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("fair_order%0d", i), i < order_q.size() ? order_q[i] : -1, i % N);

    // back-pressure: 22 stalled cycles, channel 0 keeps requesting
    bus.out_ready = 1'b0;
    set_ch(0, 8'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    bus.ch_valid = 3'b001;
    wait_grant("bp_grant_timeout");
    idle(22);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_ch_ready", bus.ch_ready, 0);
    bus.out_ready = 1'b1;
    wait_grant("bp_regrant_timeout");
    chk("bp_regrant", bus.ch_ready, 3'b001);
    @(posedge clk); #1;
    bus.ch_valid = '0;
    idle(6);
    chk("bp_acc", acc_cnt, 11);

    // asynchronous reset while a result is pending
    bus.out_ready = 1'b0;
    set_ch(1, 8'd1, 32'h0BAD_F00D, 32'h0BAD_F00D);
    send(3'b010);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_acc", acc_cnt, 0);
    chk("arst_dis", dis_cnt, 0);
    chk("arst_ch_ready", bus.ch_ready, 0);
    idle(2);
    rst = 1'b1;
    order_q.delete();
    bus.out_ready = 1'b1;
    bus.ch_valid  = '1;
    wait_results(1);
    @(posedge clk); #1;
    bus.ch_valid = '0;
    chk("arst_ptr", order_q.size() > 0 ? order_q[0] : -1, 0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
